data_mem_mmio: RTL and testbench

Data-side memory subsystem that sits directly downstream of the single-cycle RV32I core's data port (`mem_read`, `mem_write`, `mem_address`, `mem_data_to_mem`, `mem_data_from_mem`). It decodes each access to a word-addressed data RAM or a memory-mapped I/O page. The I/O page holds a FIFO-buffered 8N1 UART transmitter and an optional cycle counter. Reads return data combinationally in the same cycle, as the single-cycle core requires; all writes and state changes happen on the rising clock edge.

---
 rtl/data_mem_mmio.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_mmio.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - RV32I data-side RAM plus MMIO page with FIFO-buffered 8N1 UART TX
// Optional CYCLE counter at 0x8000_0008: define DATA_MEM_MMIO_CYCLE_COUNTER_EN.
module data_mem_mmio #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_to_mem,
  output logic [31:0] mem_data_from_mem,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [FW:0]   PTR_ONE   = (FW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  logic          is_mmio;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          data_wr;
  logic          status_wr;
  logic          unused_addr;

  assign is_mmio     = mem_address[31];
  assign reg_sel     = mem_address[3:2];
  assign ram_idx     = mem_address[AW+1:2];
  assign ram_we      = mem_write && !is_mmio;
  assign data_wr     = mem_write && is_mmio && (reg_sel == 2'd0);
  assign status_wr   = mem_write && is_mmio && (reg_sel == 2'd1);
  assign unused_addr = ^mem_address;

  // Data RAM: no reset so contents survive a core reset.
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_data_to_mem;
  end

  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [FW:0] wptr_q, wptr_d;
  logic [FW:0] rptr_q, rptr_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        ovf_event;
  logic        overflow_q, overflow_d;

  tx_state_e     state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          tx_busy;

  assign fifo_full  = (wptr_q[FW-1:0] == rptr_q[FW-1:0]) && (wptr_q[FW] != rptr_q[FW]);
  assign fifo_empty = (wptr_q == rptr_q);
  // Fullness is judged before the edge, so a same-cycle pop cannot rescue a push.
  assign push       = data_wr && !fifo_full;
  assign ovf_event  = data_wr && fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign tx_busy    = (state_q != IDLE);

  always_comb begin
    wptr_d     = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d     = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (status_wr && mem_data_to_mem[3]) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[FW-1:0]] <= mem_data_to_mem[7:0];
  end

  // Transmitter: baud_q counts down each bit period, bit_q tracks data bits sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_q[rptr_q[FW-1:0]];
            tx_q    <= 1'b0;
            baud_q  <= BAUD_LAST;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == '0) begin
            tx_q    <= shift_q[0];
            baud_q  <= BAUD_LAST;
            bit_q   <= 3'd0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LAST;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_q == '0) begin
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_tx = tx_q;

  logic [31:0] cycle_rdata;

`ifdef DATA_MEM_MMIO_CYCLE_COUNTER_EN
  logic        cycle_wr;
  logic [31:0] cycle_q, cycle_d;

  assign cycle_wr = mem_write && is_mmio && (reg_sel == 2'd2);

  // A software load takes the place of that edge's increment.
  always_comb begin
    cycle_d = cycle_wr ? mem_data_to_mem : (cycle_q + 32'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rdata = cycle_q;
`else
  assign cycle_rdata = 32'd0;
`endif

  always_comb begin
    mem_data_from_mem = 32'd0;
    if (mem_read) begin
      if (!is_mmio) begin
        mem_data_from_mem = ram_q[ram_idx];
      end else begin
        case (reg_sel)
          2'd1:    mem_data_from_mem = {28'd0, overflow_q, tx_busy, fifo_empty, fifo_full};
          2'd2:    mem_data_from_mem = cycle_rdata;
          default: mem_data_from_mem = 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - randomized self-checking bench for data_mem_mmio against a behavioural model
module tb_data_mem_mmio;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB        = 4;
  localparam int FRAME      = 10 * CPB;
  localparam int AW         = $clog2(RAM_WORDS);
  localparam logic [31:0] UART_DATA   = 32'h8000_0000;
  localparam logic [31:0] UART_STATUS = 32'h8000_0004;
  localparam logic [31:0] CYCLE_A     = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'd0;
  logic [31:0] mem_data_to_mem = 32'd0;
  logic [31:0] mem_data_from_mem;
  logic        uart_tx;

  data_mem_mmio #(
    .RAM_WORDS   (RAM_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_data_to_mem  (mem_data_to_mem),
    .mem_data_from_mem(mem_data_from_mem),
    .uart_tx          (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_v [RAM_WORDS];
  logic [7:0]  q_m[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  int          busy_m = 0;
  logic [7:0]  cur_m = 8'd0;
  bit          ovf_m = 1'b0;
  logic [31:0] cyc_m = 32'd0;

  int          rst_cnt = 0;
  int          frame_err = 0;
  logic [7:0]  mon_b;
  int          mon_r0;
  logic        mon_s0, mon_s1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!a[31]) return ram_m[a[AW+1:2]];
    case (a[3:2])
      2'd1: return {28'd0, ovf_m, (busy_m != 0), (q_m.size() == 0), (q_m.size() == FIFO_DEPTH)};
`ifdef DATA_MEM_MMIO_CYCLE_COUNTER_EN
      2'd2: return cyc_m;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Line level from position within the 10-bit frame: start, 8 data LSB first, stop.
  function automatic logic exp_tx_level();
    int pos;
    if (busy_m == 0) return 1'b1;
    pos = (FRAME - busy_m) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return cur_m[pos-1];
  endfunction

  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit full, empty, push_req;
    full     = (q_m.size() == FIFO_DEPTH);
    empty    = (q_m.size() == 0);
    push_req = wr && a[31] && (a[3:2] == 2'd0);
    if (push_req && full) ovf_m = 1'b1;
    else if (wr && a[31] && (a[3:2] == 2'd1) && d[3]) ovf_m = 1'b0;
    if (busy_m == 0 && !empty) begin
      cur_m = q_m.pop_front();
      exp_tx.push_back(cur_m);
      busy_m = FRAME;
    end else if (busy_m > 0) begin
      busy_m--;
    end
    if (push_req && !full) q_m.push_back(d[7:0]);
    if (wr && !a[31]) begin
      ram_m[a[AW+1:2]] = d;
      ram_v[a[AW+1:2]] = 1'b1;
    end
    if (wr && a[31] && (a[3:2] == 2'd2)) cyc_m = d;
    else cyc_m = cyc_m + 32'd1;
  endtask

  task automatic model_reset();
    if (busy_m != 0) void'(exp_tx.pop_back());
    q_m.delete();
    busy_m = 0;
    ovf_m  = 1'b0;
    cyc_m  = 32'd0;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    @(negedge clk);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = a;
    mem_data_to_mem = d;
    #1;
    exp = rd ? model_read(a) : 32'd0;
    if (!rd || a[31] || ram_v[a[AW+1:2]])
      check_eq($sformatf("rdata@%08h", a), mem_data_from_mem, exp);
    check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx_level()});
    @(posedge clk);
    model_edge(wr, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((busy_m != 0 || q_m.size() != 0) && guard < 2000) begin
      step(1'b1, 1'b0, UART_STATUS, 32'd0);
      guard++;
    end
    if (guard >= 2000) check_eq("drain_timeout", guard, 0);
    idle(3);
  endtask

  always @(negedge rst) rst_cnt++;

  // Serial receiver: samples mid-bit, discards any frame cut by a reset.
  initial begin
    forever begin
      @(negedge uart_tx);
      if (rst !== 1'b1) continue;
      mon_r0 = rst_cnt;
      #25 mon_s0 = uart_tx;
      for (int i = 0; i < 8; i++) begin
        #(CPB * 10) mon_b[i] = uart_tx;
      end
      #(CPB * 10) mon_s1 = uart_tx;
      if (rst_cnt == mon_r0) begin
        if (mon_s0 !== 1'b0 || mon_s1 !== 1'b1) frame_err++;
        rx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r;

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state and RAM basics
    step(1'b1, 1'b0, UART_STATUS, 32'd0);
    step(1'b1, 1'b0, CYCLE_A, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0000_0013, 32'd0);
    step(1'b1, 1'b0, 32'h0000_1010, 32'd0);
    step(1'b0, 1'b0, 32'h0000_0010, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    step(1'b1, 1'b0, 32'h0000_0010, 32'd0);

    // Single frames with per-cycle line checks
    step(1'b0, 1'b1, UART_DATA, 32'h55);
    repeat (42) step(1'b1, 1'b0, UART_STATUS, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, UART_DATA, $urandom);
      repeat (42) step(1'b1, 1'b0, UART_STATUS, 32'd0);
    end

    // FIFO full and overflow
    drain();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, UART_DATA, $urandom);
    step(1'b1, 1'b0, UART_STATUS, 32'd0);
    step(1'b0, 1'b1, UART_STATUS, 32'h8);
    step(1'b1, 1'b0, UART_STATUS, 32'd0);
    drain();

    // Cycle counter, including wrap
    step(1'b1, 1'b0, CYCLE_A, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, CYCLE_A, 32'd0);
    step(1'b0, 1'b1, CYCLE_A, 32'hFFFF_FFFE);
    repeat (3) step(1'b1, 1'b0, CYCLE_A, 32'd0);

    // Reset in the middle of a data bit
    step(1'b0, 1'b1, UART_DATA, 32'hA5);
    step(1'b0, 1'b1, UART_DATA, 32'h3C);
    step(1'b0, 1'b1, UART_DATA, 32'h0F);
    repeat (18) step(1'b1, 1'b0, UART_STATUS, 32'd0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_eq("tx_async_rst", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    step(1'b1, 1'b0, UART_STATUS, 32'd0);
    step(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    step(1'b1, 1'b0, CYCLE_A, 32'd0);
    idle(45);

    // Randomized mix
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      a = $urandom;
      if (r < 40) begin
        a[31] = 1'b0;
        a[AW+1:2] = AW'($urandom_range(0, 31));
        step(1'($urandom), 1'($urandom), a, $urandom);
      end else if (r < 50) begin
        a[31] = 1'b1;
        a[3:2] = 2'd0;
        step(1'($urandom), 1'b1, a, $urandom);
      end else if (r < 65) begin
        a[31] = 1'b1;
        a[3:2] = 2'd1;
        step(1'b1, ($urandom_range(0, 3) == 0), a, $urandom);
      end else if (r < 75) begin
        a[31] = 1'b1;
        a[3:2] = 2'($urandom_range(2, 3));
        step(1'b1, ($urandom_range(0, 2) == 0), a, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      end else begin
        step(1'b0, 1'b0, a, $urandom);
      end
    end

    drain();
    idle(10);
    check_eq("rx_count", 32'(rx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < rx_q.size() && i < exp_tx.size(); i++)
      check_eq($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_tx[i]});
    check_eq("frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
